// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for a shared WIDTH-bit register with one-cycle write acks.
// Optional REG_WRITE_ARBITER_LOCK_EN adds a per-requester lock that holds the grant for burst writes.
module reg_write_arbiter #(
    parameter int unsigned        N         = 4,
    parameter int unsigned        WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           req,
`ifdef REG_WRITE_ARBITER_LOCK_EN
    input  logic [N-1:0]           lock,
`endif
    input  logic [N*WIDTH-1:0]     wdata,
    output logic [WIDTH-1:0]       q,
    output logic [N-1:0]           ack,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy
);

    localparam int unsigned IDW = $clog2(N);

`ifdef REG_WRITE_ARBITER_LOCK_EN
    typedef enum logic [1:0] {StIdle, StWrite, StHold} state_e;
`else
    typedef enum logic [1:0] {StIdle, StWrite} state_e;
`endif

    state_e           state;
    logic [IDW-1:0]   ptr;
    logic [N-1:0]     eligible;
    logic [IDW-1:0]   pick;
    logic             found;
    logic [WIDTH-1:0] gdata;

    // A requester whose ack is high this cycle is still holding req; skip it.
    assign eligible = req & ~ack;
    assign gdata    = wdata[grant_id*WIDTH +: WIDTH];

    // First eligible requester after ptr, circularly.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            int unsigned idx;
            idx = (int'(ptr) + k) % N;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = IDW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            q        <= RESET_VAL;
            ack      <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
            ptr      <= IDW'(N - 1);
        end else begin
            ack <= '0;
            unique case (state)
                StIdle: begin
                    if (found) begin
                        grant_id <= pick;
                        busy     <= 1'b1;
                        state    <= StWrite;
                    end
                end
                StWrite: begin
                    q             <= gdata;
                    ack[grant_id] <= 1'b1;
                    ptr           <= grant_id;
`ifdef REG_WRITE_ARBITER_LOCK_EN
                    if (lock[grant_id]) begin
                        state <= StHold;
                    end else begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end
`else
                    busy  <= 1'b0;
                    state <= StIdle;
`endif
                end
`ifdef REG_WRITE_ARBITER_LOCK_EN
                StHold: begin
                    if (!lock[grant_id]) begin
                        ptr   <= grant_id;
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else if (req[grant_id]) begin
                        q             <= gdata;
                        ack[grant_id] <= 1'b1;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule
